// File: rtl/cipher_job_sequencer.sv
// Job controller: debounces the mode switches, latches a one-hot mode, then
// walks the CPU through reset, run and completion, with a run watchdog.
module cipher_job_sequencer #(
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned RST_CYCLES     = 2,
    parameter logic [31:0] DONE_ADDR      = 32'h0000_0400,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  sw,
    input  logic        wboolean,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        cpu_reset,
    output logic [6:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        refresh,
    output logic        error,
    output logic        invalid
);

    localparam int unsigned CntW  = $clog2(DEB_CYCLES);
    localparam int unsigned RcntW = $clog2(RST_CYCLES + 1);
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CntW-1:0]  CntMax  = CntW'(DEB_CYCLES - 1);
    localparam logic [RcntW-1:0] RcntMax = RcntW'(RST_CYCLES - 1);
    localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRun,
        StRefresh,
        StFault
    } state_e;

    logic [6:0]       sw_q;
    logic [6:0]       sw_stable_q;
    logic [CntW-1:0]  cnt_q;

    state_e           state_q, state_d;
    logic [6:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             refresh_q, refresh_d;
    logic             error_q, error_d;

    logic             multi_bit;
    logic             sw_onehot;
    logic             completion;

    // Switch debounce: accept sw_q once it has held for DEB_CYCLES samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q        <= '0;
            cnt_q       <= '0;
            sw_stable_q <= '0;
        end else begin
            sw_q <= sw;
            if (sw != sw_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if ((sw == sw_q) && (cnt_q == CntMax)) begin
                sw_stable_q <= sw_q;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_bit  = |(sw_stable_q & (sw_stable_q - 7'd1));
    assign sw_onehot  = (sw_stable_q != 7'd0) && !multi_bit;
    assign completion = wboolean && (address == DONE_ADDR) && wdata[0];

    // Job FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            done_q      <= 1'b0;
            rcnt_q      <= '0;
            wdog_q      <= '0;
            cpu_reset_q <= 1'b1;
            refresh_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
            rcnt_q      <= rcnt_d;
            wdog_q      <= wdog_d;
            cpu_reset_q <= cpu_reset_d;
            refresh_q   <= refresh_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic; output registers follow the state being entered.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        done_d      = done_q;
        rcnt_d      = rcnt_q;
        wdog_d      = wdog_q;
        cpu_reset_d = 1'b1;
        refresh_d   = 1'b0;
        error_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sw_onehot && (sw_stable_q != mode_q)) begin
                    mode_d  = sw_stable_q;
                    done_d  = 1'b0;
                    rcnt_d  = '0;
                    state_d = StRst;
                end
            end
            StRst: begin
                if (rcnt_q == RcntMax) begin
                    wdog_d  = '0;
                    state_d = StRun;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            StRun: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (completion) begin
                    done_d  = 1'b1;
                    state_d = StRefresh;
                end else if (wdog_q == WdogMax) begin
                    state_d = StFault;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StRefresh: begin
                state_d = StIdle;
            end
            StFault: begin
                // Clearing mode lets the same selection start a fresh job.
                if (sw_stable_q == 7'd0) begin
                    mode_d  = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cpu_reset_d = (state_d != StRun);
        refresh_d   = (state_d == StRefresh);
        error_d     = (state_d == StFault);
    end

    assign cpu_reset = cpu_reset_q;
    assign mode      = mode_q;
    assign done      = done_q;
    assign refresh   = refresh_q;
    assign error     = error_q;
    assign busy      = (state_q == StRst) || (state_q == StRun);
    assign invalid   = multi_bit;

endmodule

// File: tb/tb_cipher_job_sequencer.sv
// Directed bench for cipher_job_sequencer using default parameters.
module tb_cipher_job_sequencer;

    logic        clk;
    logic        reset;
    logic [6:0]  sw;
    logic        wboolean;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        cpu_reset;
    logic [6:0]  mode;
    logic        busy;
    logic        done;
    logic        refresh;
    logic        error;
    logic        invalid;

    int n_cmp;
    int n_fail;

    cipher_job_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .wboolean  (wboolean),
        .address   (address),
        .wdata     (wdata),
        .cpu_reset (cpu_reset),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .refresh   (refresh),
        .error     (error),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle CPU store.
    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        wboolean = 1'b1;
        address  = a;
        wdata    = d;
        tick(1);
        wboolean = 1'b0;
        address  = '0;
        wdata    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        check({tag, ".mode"},      {25'd0, mode},      32'd0);
        check({tag, ".busy"},      {31'd0, busy},      32'd0);
        check({tag, ".done"},      {31'd0, done},      32'd0);
        check({tag, ".refresh"},   {31'd0, refresh},   32'd0);
        check({tag, ".error"},     {31'd0, error},     32'd0);
        check({tag, ".invalid"},   {31'd0, invalid},   32'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        sw       = '0;
        wboolean = 1'b0;
        address  = '0;
        wdata    = '0;

        // Reset values.
        tick(2);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(3);
        check("idle_no_job", {31'd0, busy}, 32'd0);

        // swxor job: mode appears DEB_CYCLES+2 edges after the step.
        sw = 7'b0001000;
        tick(17);
        check("xor_mode_early", {25'd0, mode}, 32'd0);
        tick(1);
        check("xor_mode", {25'd0, mode}, 32'h08);
        check("xor_busy", {31'd0, busy}, 32'd1);
        check("xor_cpurst_1", {31'd0, cpu_reset}, 32'd1);
        tick(1);
        check("xor_cpurst_2", {31'd0, cpu_reset}, 32'd1);
        tick(1);
        check("xor_cpurst_low", {31'd0, cpu_reset}, 32'd0);
        check("xor_run_busy", {31'd0, busy}, 32'd1);
        tick(3);
        // Non-completing writes are ignored.
        cpu_write(32'h0000_0400, 32'h2);
        check("wdata0_zero_busy", {31'd0, busy}, 32'd1);
        check("wdata0_zero_refresh", {31'd0, refresh}, 32'd0);
        cpu_write(32'h0000_0404, 32'h1);
        check("wrong_addr_busy", {31'd0, busy}, 32'd1);
        // Real completion.
        cpu_write(32'h0000_0400, 32'h1);
        check("cmp_refresh", {31'd0, refresh}, 32'd1);
        check("cmp_done", {31'd0, done}, 32'd1);
        check("cmp_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("cmp_busy", {31'd0, busy}, 32'd0);
        tick(1);
        check("cmp_refresh_one", {31'd0, refresh}, 32'd0);
        check("cmp_done_hold", {31'd0, done}, 32'd1);
        tick(3);
        check("same_mode_no_rerun", {31'd0, busy}, 32'd0);
        check("same_mode_kept", {25'd0, mode}, 32'h08);

        // Glitch shorter than the debounce window after a fresh reset.
        sw    = '0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sw    = 7'b0100000;
        tick(5);
        sw = '0;
        tick(25);
        check("glitch_mode", {25'd0, mode}, 32'd0);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_cpurst", {31'd0, cpu_reset}, 32'd1);

        // Two bits set: invalid, no job.
        sw = 7'b0000011;
        tick(16);
        check("inv_early", {31'd0, invalid}, 32'd0);
        tick(1);
        check("inv_set", {31'd0, invalid}, 32'd1);
        tick(3);
        check("inv_no_job", {31'd0, busy}, 32'd0);
        check("inv_mode", {25'd0, mode}, 32'd0);
        sw = 7'b0000001;
        tick(16);
        check("inv_hold", {31'd0, invalid}, 32'd1);
        tick(1);
        check("inv_clear", {31'd0, invalid}, 32'd0);
        tick(1);
        check("xor2_mode", {25'd0, mode}, 32'h01);
        check("xor2_busy", {31'd0, busy}, 32'd1);

        // Watchdog: FAULT exactly TIMEOUT_CYCLES after RUN entry.
        tick(2);
        check("wd_run", {31'd0, cpu_reset}, 32'd0);
        tick(4095);
        check("wd_not_yet", {31'd0, error}, 32'd0);
        check("wd_still_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("wd_error", {31'd0, error}, 32'd1);
        check("wd_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("wd_busy", {31'd0, busy}, 32'd0);
        cpu_write(32'h0000_0400, 32'h1);
        check("fault_write_error", {31'd0, error}, 32'd1);
        check("fault_write_refresh", {31'd0, refresh}, 32'd0);
        check("fault_write_done", {31'd0, done}, 32'd0);
        sw = '0;
        tick(17);
        check("fault_hold", {31'd0, error}, 32'd1);
        tick(1);
        check("fault_exit_error", {31'd0, error}, 32'd0);
        check("fault_exit_mode", {25'd0, mode}, 32'd0);
        sw = 7'b0010000;
        tick(18);
        check("not_mode", {25'd0, mode}, 32'h10);
        check("not_busy", {31'd0, busy}, 32'd1);

        // Switch change during RUN waits for the job to finish.
        tick(2);
        sw = 7'b1000000;
        tick(20);
        check("midrun_mode_kept", {25'd0, mode}, 32'h10);
        check("midrun_running", {31'd0, cpu_reset}, 32'd0);
        cpu_write(32'h0000_0400, 32'h1);
        check("midrun_refresh", {31'd0, refresh}, 32'd1);
        check("midrun_done", {31'd0, done}, 32'd1);
        tick(1);
        check("midrun_idle", {31'd0, busy}, 32'd0);
        tick(1);
        check("init_mode", {25'd0, mode}, 32'h40);
        check("init_done_clr", {31'd0, done}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd1);

        // Mid-RUN synchronous reset, switch held.
        tick(5);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        reset = 1'b0;
        tick(17);
        check("restart_early", {25'd0, mode}, 32'd0);
        tick(1);
        check("restart_mode", {25'd0, mode}, 32'h40);
        check("restart_busy", {31'd0, busy}, 32'd1);

        // Completion on the final watchdog cycle wins over the timeout.
        tick(2);
        check("race_run", {31'd0, cpu_reset}, 32'd0);
        tick(4095);
        cpu_write(32'h0000_0400, 32'h1);
        check("race_refresh", {31'd0, refresh}, 32'd1);
        check("race_error", {31'd0, error}, 32'd0);
        check("race_done", {31'd0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cipher_job_sequencer.md
# cipher_job_sequencer

Job controller between the board mode switches and the CPU/character pipeline. It debounces the seven mode switches and latches a valid one-hot selection as the active mode. It then sequences the CPU through a job: hold in reset, release, and wait for a completion write to a mailbox address. On completion it pulses a refresh so the character manager and VGA path redraw the processed text. A run watchdog traps hung jobs.

## Interface
- DEB_CYCLES, 16: consecutive identical samples needed to accept a new switch vector (≥2).
- RST_CYCLES, 2: cycles cpu_reset is held high at job start (≥1).
- DONE_ADDR, 32'h0000_0400: CPU store address used as the completion mailbox.
- TIMEOUT_CYCLES, 4096: maximum RUN cycles before a fault.
- clk  in  1  system clock (the divided CPU/VGA clock).
- reset  in  1  synchronous, active-high reset.
- sw  in  7  raw switches {swinit, swadd, swnot, swxor, swxor0, swxor1, swxor2}, bit 6 = swinit.
- wboolean  in  1  CPU data-write enable.
- address  in  32  CPU data address.
- wdata  in  32  CPU write data.
- cpu_reset  out  1  reset driven to the CPU.
- mode  out  7  latched one-hot active mode, or 0 for none.
- busy  out  1  high in RST and RUN.
- done  out  1  level, last job completed.
- refresh  out  1  one-cycle redraw strobe.
- error  out  1  level, watchdog fault.
- invalid  out  1  level, debounced vector has more than one bit set.

## Operation
- Debounce:
  - sw_q registers sw every cycle; cnt counts cycles with sw_q unchanged, saturating.
  - When cnt reaches DEB_CYCLES-1 with sw_q still unchanged, sw_stable <= sw_q.
  - Any change of sw_q clears cnt.
- invalid = (popcount(sw_stable) > 1), combinational from sw_stable.
- FSM states and transitions:
  - IDLE: cpu_reset=1. If sw_stable is one-hot and != mode: mode <= sw_stable, done <= 0, rcnt <= 0, go to RST. A zero or invalid vector does nothing.
  - RST: cpu_reset=1 for RST_CYCLES cycles, then go to RUN and clear the watchdog counter.
  - RUN: cpu_reset=0. A completion is a cycle with wboolean && address==DONE_ADDR && wdata[0]==1. On completion, go to REFRESH. Otherwise, if wdog==TIMEOUT_CYCLES-1, go to FAULT; else wdog++.
  - REFRESH: refresh=1 for exactly one cycle, done <= 1, cpu_reset=1, then go to IDLE.
  - FAULT: cpu_reset=1, error=1. Exit to IDLE only when sw_stable==0; on exit clear error and mode (so any re-selected mode restarts).
- Switch changes during RST, RUN or REFRESH are debounced but not acted on until IDLE. On return to IDLE, a different stable one-hot vector starts a new job immediately.
- Re-selecting the same mode does not rerun. To rerun the same mode, toggle the switches through 0 or another mode.
- Writes to DONE_ADDR with wdata[0]==0, and writes outside RUN, are ignored.
- Completion and timeout in the same cycle: completion wins.

## Timing
- Reset (synchronous, dominates everything):
  - Outputs: cpu_reset=1, mode=0, busy=0, done=0, refresh=0, error=0, invalid=0.
  - Internal: sw_q=0, sw_stable=0, cnt=0, FSM in IDLE.
- All outputs are registered except invalid and busy, which decode from registered state.
- Switch-to-accept latency: a step on sw becomes sw_stable DEB_CYCLES+1 cycles after the step, counting the sw_q register.
- IDLE decision: the FSM samples sw_stable the cycle after it updates.
- From sw_stable update:
  - mode and RST are entered 1 cycle later.
  - cpu_reset falls RST_CYCLES cycles after that.
- Completion: in the cycle after the completion write, refresh=1 and done=1 (done is registered on REFRESH entry). IDLE follows one cycle later.
- Timeout: FAULT is entered exactly TIMEOUT_CYCLES RUN cycles after RUN entry if no completion occurs.

## Test plan
- Reset, then assert only swxor (sw=7'b0001000) steady:
  - mode=0001000 after DEB_CYCLES+2 cycles; cpu_reset high for 2 cycles then low; busy=1.
  - Write address=0x400, wdata=1 → refresh pulses exactly 1 cycle, done=1, cpu_reset=1, busy=0.
- Glitch: toggle swadd for 5 cycles (< DEB_CYCLES), then release:
  - mode stays 0, no job starts, cpu_reset stays 1.
- Set sw=7'b0000011:
  - invalid=1, no job starts.
  - Then change to 7'b0000001 → invalid=0 and a job starts with mode=0000001.
- Start a job, issue no completion write:
  - Exactly 4096 RUN cycles later error=1, cpu_reset=1.
  - A completion write afterward is ignored.
  - sw=0 → error=0, mode=0; re-assert swnot → new job.
- During RUN, switch from swxor to swinit and wait for it to debounce:
  - mode unchanged until completion; after REFRESH→IDLE a new job starts with mode=1000000, done cleared.
- Mid-RUN reset pulse:
  - Next cycle all outputs are at reset values.
  - With the switch still held, a job restarts after DEB_CYCLES+2 cycles.
